fp_mul_pipe: RTL

Parametrised, fully pipelined IEEE-754-style floating-point multiplier for the accelerator FP datapath. Generalises exponent/fraction widths and adds a valid/ready handshake with per-stage bubble collapsing, full special-value handling (zero, infinity, NaN), round-to-nearest-even and exception flags. One result per cycle at full throughput, fixed 3-cycle latency, consumed by the accelerator's FP result bus.

---
 rtl/fp_mul_pipe.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage pipelined floating-point multiplier with a
// valid/ready handshake on both sides.
//
// Word format is {sign, exp[E_BIT-1:0], frac[F_BIT-1:0]}. Subnormal inputs are
// treated as signed zero. Every stage can hold a result. A held stage keeps
// its contents, and empty stages always accept, so bubbles collapse.
//
// Build option: define FP_MUL_RNE_EN for round-to-nearest-even, where overflow
// gives signed infinity. Without it, results are truncated and overflow
// saturates to signed max finite. The flags are the same in both builds.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   stage 1 can accept (combinational from out_ready)
//   in_a/in_b  operands
//   out_valid  result valid
//   out_ready  downstream accepts
//   out_p      product
//   out_flags  {invalid, overflow, underflow, inexact} for out_p
module fp_mul_pipe #(
  parameter int  E_BIT = 8,
  parameter int  F_BIT = 23,
  localparam int W     = 1 + E_BIT + F_BIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic [3:0]   out_flags
);

  localparam int PW = 2 * F_BIT + 2;
  localparam int XW = E_BIT + 2;
  localparam logic signed [XW-1:0] BIAS_S     = XW'((1 << (E_BIT - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_ONES_S = XW'((1 << E_BIT) - 1);
  // Selects the product bits below the round bit when no normalising shift occurs.
  localparam logic [F_BIT-2:0] STICKY_MASK = {(F_BIT - 1){1'b1}} >> 1;
  localparam logic [W-1:0] CANON_NAN = {1'b0, {E_BIT{1'b1}}, 1'b1, {(F_BIT - 1){1'b0}}};

`ifdef FP_MUL_RNE_EN
  // The result is one bit wider than the fraction. The top bit is the carry into the exponent.
  function automatic logic [F_BIT:0] round_sig(input logic [F_BIT-1:0] frac,
                                               input logic g, input logic r, input logic s);
    logic up;
    up = g & (r | s | frac[0]);
    return {1'b0, frac} + {{F_BIT{1'b0}}, up};
  endfunction

  function automatic logic [W-1:0] ovf_value(input logic s);
    return {s, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
  endfunction
`else
  function automatic logic [F_BIT:0] round_sig(input logic [F_BIT-1:0] frac);
    return {1'b0, frac};
  endfunction

  function automatic logic [W-1:0] ovf_value(input logic s);
    return {s, {(E_BIT - 1){1'b1}}, 1'b0, {F_BIT{1'b1}}};
  endfunction
`endif

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic adv1, adv2, adv3;

  // Each stage moves when it is empty or when the stage after it moves.
  always_comb begin
    adv3 = !v3_q || out_ready;
    adv2 = !v2_q || adv3;
    adv1 = !v1_q || adv2;
  end

  assign in_ready  = adv1;
  assign out_valid = v3_q;

  logic [E_BIT-1:0] ea, eb;
  logic [F_BIT-1:0] fa, fb;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  assign ea = in_a[W-2:F_BIT];
  assign eb = in_b[W-2:F_BIT];
  assign fa = in_a[F_BIT-1:0];
  assign fb = in_b[F_BIT-1:0];

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == {E_BIT{1'b1}}) && (fa == '0);
    b_inf  = (eb == {E_BIT{1'b1}}) && (fb == '0);
    a_nan  = (ea == {E_BIT{1'b1}}) && (fa != '0);
    b_nan  = (eb == {E_BIT{1'b1}}) && (fb != '0);
  end

  // ---- stage 1: classify, multiply significands, add exponents ----
  logic                 sign_p1_q, sign_p1_d, nan_p1_q, nan_p1_d, inv_p1_q, inv_p1_d;
  logic                 inf_p1_q, inf_p1_d, zero_p1_q, zero_p1_d;
  logic signed [XW-1:0] exp_p1_q, exp_p1_d;
  logic [PW-1:0]        prod_p1_q, prod_p1_d;

  always_comb begin
    v1_d      = adv1 ? in_valid : v1_q;
    sign_p1_d = sign_p1_q;
    nan_p1_d  = nan_p1_q;
    inv_p1_d  = inv_p1_q;
    inf_p1_d  = inf_p1_q;
    zero_p1_d = zero_p1_q;
    exp_p1_d  = exp_p1_q;
    prod_p1_d = prod_p1_q;
    if (adv1 && in_valid) begin
      sign_p1_d = in_a[W-1] ^ in_b[W-1];
      nan_p1_d  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
      // inf x zero is invalid only when no operand is already NaN.
      inv_p1_d  = !(a_nan | b_nan) & ((a_inf & b_zero) | (a_zero & b_inf));
      inf_p1_d  = a_inf | b_inf;
      zero_p1_d = a_zero | b_zero;
      exp_p1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
      prod_p1_d = {{(F_BIT + 1){1'b0}}, 1'b1, fa} * {{(F_BIT + 1){1'b0}}, 1'b1, fb};
    end
  end

  // ---- stage 2: normalise and split out guard/round/sticky ----
  logic                 sign_p2_q, sign_p2_d, nan_p2_q, nan_p2_d, inv_p2_q, inv_p2_d;
  logic                 inf_p2_q, inf_p2_d, zero_p2_q, zero_p2_d;
  logic signed [XW-1:0] exp_p2_q, exp_p2_d;
  logic [F_BIT-1:0]     frac_p2_q, frac_p2_d;
  logic                 g_p2_q, g_p2_d, r_p2_q, r_p2_d, s_p2_q, s_p2_d;
  logic                 msb_p1;

  always_comb begin
    msb_p1    = prod_p1_q[PW-1];
    v2_d      = adv2 ? v1_q : v2_q;
    sign_p2_d = sign_p2_q;
    nan_p2_d  = nan_p2_q;
    inv_p2_d  = inv_p2_q;
    inf_p2_d  = inf_p2_q;
    zero_p2_d = zero_p2_q;
    exp_p2_d  = exp_p2_q;
    frac_p2_d = frac_p2_q;
    g_p2_d    = g_p2_q;
    r_p2_d    = r_p2_q;
    s_p2_d    = s_p2_q;
    if (adv2 && v1_q) begin
      sign_p2_d = sign_p1_q;
      nan_p2_d  = nan_p1_q;
      inv_p2_d  = inv_p1_q;
      inf_p2_d  = inf_p1_q;
      zero_p2_d = zero_p1_q;
      // A product in [2,4) is shifted right one place, which means every field moves up a bit.
      exp_p2_d  = exp_p1_q + $signed({{(XW - 1){1'b0}}, msb_p1});
      frac_p2_d = msb_p1 ? prod_p1_q[PW-2:F_BIT+1] : prod_p1_q[PW-3:F_BIT];
      g_p2_d    = msb_p1 ? prod_p1_q[F_BIT]       : prod_p1_q[F_BIT-1];
      r_p2_d    = msb_p1 ? prod_p1_q[F_BIT-1]     : prod_p1_q[F_BIT-2];
      s_p2_d    = msb_p1 ? |prod_p1_q[F_BIT-2:0]  : |(prod_p1_q[F_BIT-2:0] & STICKY_MASK);
    end
  end

  // ---- stage 3: round, range check, special values ----
  logic [W-1:0]         out_p_q, out_p_d;
  logic [3:0]           out_flags_q, out_flags_d;
  logic [F_BIT:0]       rounded;
  logic signed [XW-1:0] exp_r;
  logic                 tiny;

  always_comb begin
`ifdef FP_MUL_RNE_EN
    rounded = round_sig(frac_p2_q, g_p2_q, r_p2_q, s_p2_q);
`else
    rounded = round_sig(frac_p2_q);
`endif
    // A rounding carry wraps the fraction to zero, which gives significand 1.0 at exponent+1.
    exp_r       = exp_p2_q + $signed({{(XW - 1){1'b0}}, rounded[F_BIT]});
    tiny        = exp_p2_q[XW-1] || (exp_p2_q == '0);
    v3_d        = adv3 ? v2_q : v3_q;
    out_p_d     = out_p_q;
    out_flags_d = out_flags_q;
    if (adv3 && v2_q) begin
      if (nan_p2_q) begin
        out_p_d     = CANON_NAN;
        out_flags_d = {inv_p2_q, 3'b000};
      end else if (inf_p2_q) begin
        out_p_d     = {sign_p2_q, {E_BIT{1'b1}}, {F_BIT{1'b0}}};
        out_flags_d = 4'b0000;
      end else if (zero_p2_q) begin
        out_p_d     = {sign_p2_q, {(W - 1){1'b0}}};
        out_flags_d = 4'b0000;
      end else if (tiny) begin
        out_p_d     = {sign_p2_q, {(W - 1){1'b0}}};
        out_flags_d = 4'b0011;
      end else if (exp_r >= EXP_ONES_S) begin
        out_p_d     = ovf_value(sign_p2_q);
        out_flags_d = 4'b0101;
      end else begin
        out_p_d     = {sign_p2_q, exp_r[E_BIT-1:0], rounded[F_BIT-1:0]};
        out_flags_d = {3'b000, g_p2_q | r_p2_q | s_p2_q};
      end
    end
  end

  assign out_p     = out_p_q;
  assign out_flags = out_flags_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_p_q     <= '0;
      out_flags_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      out_p_q     <= out_p_d;
      out_flags_q <= out_flags_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    nan_p1_q  <= nan_p1_d;
    inv_p1_q  <= inv_p1_d;
    inf_p1_q  <= inf_p1_d;
    zero_p1_q <= zero_p1_d;
    exp_p1_q  <= exp_p1_d;
    prod_p1_q <= prod_p1_d;
    sign_p2_q <= sign_p2_d;
    nan_p2_q  <= nan_p2_d;
    inv_p2_q  <= inv_p2_d;
    inf_p2_q  <= inf_p2_d;
    zero_p2_q <= zero_p2_d;
    exp_p2_q  <= exp_p2_d;
    frac_p2_q <= frac_p2_d;
    g_p2_q    <= g_p2_d;
    r_p2_q    <= r_p2_d;
    s_p2_q    <= s_p2_d;
  end

endmodule
